// File: rtl/picorv_pcpi_pkg.sv
// Shared types for the PCPI initiator slice.
// Holds the FSM state encoding and the RV32M decode constants.
package picorv_pcpi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } pcpi_state_t;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic is_muldiv(input logic [31:0] insn);
        return (insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/pcpi_watchdog.sv
// Purpose: 8-bit stall counter that flags when TIMEOUT-1 idle BUSY cycles have elapsed.
// Latency: count updates one cycle after clear/inc; expired is combinational from count.
// Backpressure: none; clear has priority over inc.
module pcpi_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       inc,
    output logic [7:0] count,
    output logic       expired
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (inc) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/pcpi_initiator.sv
// Purpose: dispatches one command to a PCPI coprocessor and returns its result; watchdog under PCPI_TIMEOUT_EN.
// Latency: cmd accepted at N -> pcpi_valid at N+1; pcpi_ready at M -> rsp_valid at M+1.
// Backpressure: single outstanding op; cmd_ready low until the response is taken with rsp_ready.
module pcpi_initiator
    import picorv_pcpi_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [31:0]     cmd_insn,
    input  logic [XLEN-1:0] cmd_rs1,
    input  logic [XLEN-1:0] cmd_rs2,
    output logic            pcpi_valid,
    output logic [31:0]     pcpi_insn,
    output logic [XLEN-1:0] pcpi_rs1,
    output logic [XLEN-1:0] pcpi_rs2,
    input  logic            pcpi_wr,
    input  logic            pcpi_wait,
    input  logic            pcpi_ready,
    input  logic [XLEN-1:0] pcpi_rd,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_wr,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_timeout
);

    pcpi_state_t state_q, state_d;
    logic        cmd_fire;
    logic        busy;
    logic        pcpi_done;
    logic        timeout_hit;

    assign cmd_fire  = (state_q == ST_IDLE) && cmd_valid;
    assign busy      = (state_q == ST_BUSY);
    assign pcpi_done = busy && pcpi_ready;

`ifdef PCPI_TIMEOUT_EN
    logic [7:0] wd_count;
    logic       wd_expired;
    logic       rsp_timeout_q;

    // Saturate rather than wrap so a stalled count can never alias back below expiry.
    pcpi_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (cmd_fire || (busy && pcpi_wait)),
        .inc     (busy && !pcpi_wait && !pcpi_ready && (wd_count != 8'hFF)),
        .count   (wd_count),
        .expired (wd_expired)
    );

    // A result arriving in the expiry cycle wins over the abort.
    assign timeout_hit = busy && !pcpi_ready && wd_expired;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rsp_timeout_q <= 1'b0;
        end else if (pcpi_done) begin
            rsp_timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            rsp_timeout_q <= 1'b1;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    logic unused_wait;

    assign unused_wait = pcpi_wait;
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        pcpi_valid = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                pcpi_valid = 1'b1;
                if (pcpi_ready || timeout_hit) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pcpi_insn <= 32'd0;
            pcpi_rs1  <= '0;
            pcpi_rs2  <= '0;
            rsp_wr    <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (cmd_fire) begin
                pcpi_insn <= cmd_insn;
                pcpi_rs1  <= cmd_rs1;
                pcpi_rs2  <= cmd_rs2;
            end
            if (pcpi_done) begin
                rsp_wr   <= pcpi_wr;
                rsp_data <= pcpi_wr ? pcpi_rd : '0;
            end else if (timeout_hit) begin
                rsp_wr   <= 1'b0;
                rsp_data <= '0;
            end
        end
    end

endmodule
